// File: rtl/carregador_disco_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | carregador_disco_if : request and disk/memory bus bundle for the loader    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface carregador_disco_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             dir;
  logic [31:0]      disk_base;
  logic [31:0]      mem_base;
  logic [CNT_W-1:0] word_count;
  logic             busy;
  logic             done;
  logic             err;
  logic [31:0]      disk_addr;
  logic             disk_we;
  logic [31:0]      disk_wdata;
  logic [31:0]      disk_rdata;
  logic [31:0]      mem_addr;
  logic             mem_we;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;

  // master: requester plus the disk/memory models; slave: the transfer engine
  modport master (
    output start, dir, disk_base, mem_base, word_count, disk_rdata, mem_rdata,
    input  busy, done, err, disk_addr, disk_we, disk_wdata, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    input  start, dir, disk_base, mem_base, word_count, disk_rdata, mem_rdata,
    output busy, done, err, disk_addr, disk_we, disk_wdata, mem_addr, mem_we, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/carregador_disco.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | carregador_disco : pipelined DMA block copy between disk and main memory   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module carregador_disco #(
  parameter int DISK_WORDS = 100,
  parameter int CNT_W      = 16
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  carregador_disco_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_XFER  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [32:0] c_DISK_LIMIT = 33'(DISK_WORDS);

  state_t           r_state;
  logic             r_dir;
  logic             r_rej;
  logic [31:0]      r_disk_base;
  logic [31:0]      r_mem_base;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_idx;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [31:0]      r_disk_addr;
  logic             r_disk_we;
  logic [31:0]      r_disk_wdata;
  logic [31:0]      r_mem_addr;
  logic             r_mem_we;
  logic [31:0]      r_mem_wdata;

  logic [32:0]      w_req_end;
  logic             w_req_bad;
  logic [CNT_W:0]   w_idx_p2;
  logic             w_src_more;
  logic             w_multi;
  logic             w_last;
  logic [31:0]      w_disk_sink;
  logic [31:0]      w_mem_sink;

  // 33-bit sum so a base near 2^32 cannot wrap past the capacity check
  assign w_req_end   = {1'b0, bus.disk_base} + 33'(bus.word_count);
  assign w_req_bad   = w_req_end > c_DISK_LIMIT;
  // source runs one word ahead of the sink; stop it at base+N-1
  assign w_idx_p2    = {1'b0, r_idx} + (CNT_W+1)'(2);
  assign w_src_more  = w_idx_p2 < {1'b0, r_count};
  assign w_multi     = r_count > CNT_W'(1);
  assign w_last      = r_idx == (r_count - CNT_W'(1));
  assign w_disk_sink = r_disk_base + 32'(r_idx);
  assign w_mem_sink  = r_mem_base + 32'(r_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_dir        <= 1'b0;
      r_rej        <= 1'b0;
      r_disk_base  <= '0;
      r_mem_base   <= '0;
      r_count      <= '0;
      r_idx        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_disk_addr  <= '0;
      r_disk_we    <= 1'b0;
      r_disk_wdata <= '0;
      r_mem_addr   <= '0;
      r_mem_we     <= 1'b0;
      r_mem_wdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_dir       <= bus.dir;
            r_disk_base <= bus.disk_base;
            r_mem_base  <= bus.mem_base;
            r_count     <= bus.word_count;
            r_idx       <= '0;
            r_err       <= 1'b0;
            if (bus.word_count == '0) begin
              r_rej   <= 1'b0;
              r_state <= S_DONE;
            end else if (w_req_bad) begin
              r_rej   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_rej   <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= S_PRIME;
              if (bus.dir) r_mem_addr  <= bus.mem_base;
              else         r_disk_addr <= bus.disk_base;
            end
          end
        end
        S_PRIME: begin
          if (w_multi) begin
            if (r_dir) r_mem_addr  <= r_mem_addr + 32'd1;
            else       r_disk_addr <= r_disk_addr + 32'd1;
          end
          r_state <= S_XFER;
        end
        S_XFER: begin
          if (r_dir) begin
            r_disk_wdata <= bus.mem_rdata;
            r_disk_addr  <= w_disk_sink;
            r_disk_we    <= 1'b1;
            if (w_src_more) r_mem_addr <= r_mem_addr + 32'd1;
          end else begin
            r_mem_wdata <= bus.disk_rdata;
            r_mem_addr  <= w_mem_sink;
            r_mem_we    <= 1'b1;
            if (w_src_more) r_disk_addr <= r_disk_addr + 32'd1;
          end
          r_idx <= r_idx + CNT_W'(1);
          if (w_last) r_state <= S_DONE;
        end
        S_DONE: begin
          r_disk_we <= 1'b0;
          r_mem_we  <= 1'b0;
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_err     <= r_rej;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.disk_addr  = r_disk_addr;
  assign bus.disk_we    = r_disk_we;
  assign bus.disk_wdata = r_disk_wdata;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_wdata  = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_carregador_disco.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_carregador_disco : directed self-checking bench for carregador_disco    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_carregador_disco;
  localparam int DISK_WORDS = 100;
  localparam int CNT_W      = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  carregador_disco_if #(.CNT_W(CNT_W)) bus ();

  carregador_disco #(
    .DISK_WORDS(DISK_WORDS),
    .CNT_W     (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [31:0] disk_mem [0:127];
  logic [31:0] main_mem [0:1023];
  logic [6:0]  r_disk_a;

  // disk latches the address on posedge and presents data on the following negedge
  always @(posedge clk) begin
    r_disk_a <= bus.disk_addr[6:0];
    if (bus.disk_we && (bus.disk_addr < 32'(DISK_WORDS)))
      disk_mem[bus.disk_addr[6:0]] <= bus.disk_wdata;
    bus.mem_rdata <= main_mem[bus.mem_addr[9:0]];
    if (bus.mem_we)
      main_mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
  end

  always @(negedge clk) bus.disk_rdata <= disk_mem[r_disk_a];

  function automatic logic [31:0] img(input int k);
    if (k == 0)       return 32'h5800_002E;
    else if (k == 70) return 32'h6000_0000;
    else              return 32'h1000_0000 + 32'(k) * 32'h0000_0101;
  endfunction

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  int   res_done_cyc, res_done_cnt, res_mwe, res_dwe, res_first_we;
  logic res_busy0, res_err_done;

  // k counts posedges after the accepting edge t0; outputs sampled 1ns after each edge
  task automatic run_xfer(input logic d, input logic [31:0] db, input logic [31:0] mb,
                          input logic [15:0] n, input int inject_k);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.dir = d; bus.disk_base = db; bus.mem_base = mb; bus.word_count = n;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    res_busy0    = bus.busy;
    res_done_cyc = -1; res_done_cnt = 0; res_mwe = 0; res_dwe = 0; res_first_we = -1;
    res_err_done = 1'bx;
    for (int k = 1; k <= int'(n) + 8; k++) begin
      if (k == inject_k) begin
        bus.start = 1'b1; bus.dir = ~d; bus.disk_base = 32'd0;
        bus.mem_base = 32'd600; bus.word_count = 16'd5;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      if (bus.mem_we) begin res_mwe++; if (res_first_we < 0) res_first_we = k; end
      if (bus.disk_we) begin res_dwe++; if (res_first_we < 0) res_first_we = k; end
      if (bus.done) begin
        res_done_cnt++;
        if (res_done_cyc < 0) begin res_done_cyc = k; res_err_done = bus.err; end
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_busy"},       32'(bus.busy),    32'd0);
    check({pfx, "_done"},       32'(bus.done),    32'd0);
    check({pfx, "_err"},        32'(bus.err),     32'd0);
    check({pfx, "_disk_addr"},  bus.disk_addr,    32'd0);
    check({pfx, "_disk_we"},    32'(bus.disk_we), 32'd0);
    check({pfx, "_disk_wdata"}, bus.disk_wdata,   32'd0);
    check({pfx, "_mem_addr"},   bus.mem_addr,     32'd0);
    check({pfx, "_mem_we"},     32'(bus.mem_we),  32'd0);
    check({pfx, "_mem_wdata"},  bus.mem_wdata,    32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dcnt;
    for (int i = 0; i < 128; i++)  disk_mem[i] = (i < DISK_WORDS) ? img(i) : 32'd0;
    for (int i = 0; i < 1024; i++) main_mem[i] = 32'hDEAD_BEEF;
    main_mem[200] = 32'd9; main_mem[201] = 32'd6; main_mem[202] = 32'd8; main_mem[203] = 32'd7;
    bus.start = 1'b0; bus.dir = 1'b0; bus.disk_base = '0; bus.mem_base = '0; bus.word_count = '0;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    // LOAD of the 71-word boot image
    run_xfer(1'b0, 32'd0, 32'd0, 16'd71, 0);
    check("load_busy0",    32'(res_busy0),    32'd1);
    check("load_done_cyc", 32'(res_done_cyc), 32'd73);
    check("load_done_cnt", 32'(res_done_cnt), 32'd1);
    check("load_mwe_cnt",  32'(res_mwe),      32'd71);
    check("load_dwe_cnt",  32'(res_dwe),      32'd0);
    check("load_first_we", 32'(res_first_we), 32'd2);
    check("load_err",      32'(res_err_done), 32'd0);
    check("load_mem0",     main_mem[0],       32'h5800_002E);
    check("load_mem70",    main_mem[70],      32'h6000_0000);
    for (int k = 1; k < 70; k++) check($sformatf("load_mem%0d", k), main_mem[k], img(k));
    check("load_mem71",    main_mem[71],      32'hDEAD_BEEF);

    // STORE to the last four disk words (top-of-range boundary, accepted)
    run_xfer(1'b1, 32'd96, 32'd200, 16'd4, 0);
    check("store_busy0",    32'(res_busy0),    32'd1);
    check("store_done_cyc", 32'(res_done_cyc), 32'd6);
    check("store_dwe_cnt",  32'(res_dwe),      32'd4);
    check("store_mwe_cnt",  32'(res_mwe),      32'd0);
    check("store_first_we", 32'(res_first_we), 32'd2);
    check("store_err",      32'(res_err_done), 32'd0);
    check("store_disk96",   disk_mem[96],      32'd9);
    check("store_disk97",   disk_mem[97],      32'd6);
    check("store_disk98",   disk_mem[98],      32'd8);
    check("store_disk99",   disk_mem[99],      32'd7);

    // zero-length request
    run_xfer(1'b0, 32'd5, 32'd0, 16'd0, 0);
    check("zero_busy0",    32'(res_busy0),    32'd0);
    check("zero_done_cyc", 32'(res_done_cyc), 32'd1);
    check("zero_done_cnt", 32'(res_done_cnt), 32'd1);
    check("zero_err",      32'(res_err_done), 32'd0);
    check("zero_we_cnt",   32'(res_mwe + res_dwe), 32'd0);

    // out-of-range request: 97+4 > 100
    run_xfer(1'b0, 32'd97, 32'd0, 16'd4, 0);
    check("rej_busy0",    32'(res_busy0),    32'd0);
    check("rej_done_cyc", 32'(res_done_cyc), 32'd1);
    check("rej_err",      32'(res_err_done), 32'd1);
    check("rej_we_cnt",   32'(res_mwe + res_dwe), 32'd0);
    check("rej_err_held", 32'(bus.err),      32'd1);

    // start pulsed while busy must be ignored
    run_xfer(1'b0, 32'd20, 32'd500, 16'd10, 3);
    check("busy_done_cyc", 32'(res_done_cyc), 32'd12);
    check("busy_done_cnt", 32'(res_done_cnt), 32'd1);
    check("busy_mwe_cnt",  32'(res_mwe),      32'd10);
    check("busy_dwe_cnt",  32'(res_dwe),      32'd0);
    check("busy_err",      32'(res_err_done), 32'd0);
    for (int k = 0; k < 10; k++) check($sformatf("busy_mem%0d", 500 + k), main_mem[500 + k], img(20 + k));
    check("busy_mem600",   main_mem[600],     32'hDEAD_BEEF);

    // asynchronous reset while word 5 is being strobed
    @(posedge clk); #1;
    bus.start = 1'b1; bus.dir = 1'b0; bus.disk_base = 32'd30; bus.mem_base = 32'd300; bus.word_count = 16'd20;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    check("mid_mem_we_before", 32'(bus.mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    dcnt = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.done) dcnt++;
    end
    check("mid_done_cnt", 32'(dcnt), 32'd0);
    check("mid_mem300",   main_mem[300], img(30));
    check("mid_mem304",   main_mem[304], img(34));
    check("mid_mem305",   main_mem[305], 32'hDEAD_BEEF);
    @(negedge clk); rst_n = 1'b1;

    run_xfer(1'b0, 32'd50, 32'd700, 16'd3, 0);
    check("post_done_cyc", 32'(res_done_cyc), 32'd5);
    check("post_mwe_cnt",  32'(res_mwe),      32'd3);
    check("post_err",      32'(res_err_done), 32'd0);
    for (int k = 0; k < 3; k++) check($sformatf("post_mem%0d", 700 + k), main_mem[700 + k], img(50 + k));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
